// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-lane flop data memory with aligned/extended loads,
// misalignment suppression, stall hold and MEM/WB output registers.

module mem_lane #(
  parameter int NB_WADDR = 6
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_we,
  input  logic [NB_WADDR-1:0] i_waddr,
  input  logic [7:0]          i_wdata,
  output logic [7:0]          o_rdata
);
  localparam int DEPTH = 2**NB_WADDR;

  logic [DEPTH-1:0][7:0] mem;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)  mem          <= '0;
    else if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_waddr];
endmodule

module mem_stage #(
  parameter int NB_REG   = 32,
  parameter int NB_WADDR = 6
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [NB_REG-1:0] i_alu_result,
  input  logic [NB_REG-1:0] i_write_data,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_width,
  input  logic              i_sign_ext,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [4:0]        i_rd_addr,
  input  logic              i_stall,
  output logic [NB_REG-1:0] o_read_data,
  output logic [NB_REG-1:0] o_alu_result,
  output logic [4:0]        o_rd_addr,
  output logic              o_reg_write,
  output logic              o_mem_to_reg,
  output logic              o_misaligned
);
  localparam int NB_LANE = NB_REG/8;

  logic [NB_WADDR-1:0] widx;
  logic [1:0]          lane;
  logic                misaligned, we, ld_ok, both;
  logic [NB_LANE-1:0]  be, lane_we;
  logic [NB_REG-1:0]   wdata, rword, ld_data;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;

  // Upper address bits are dropped, so accesses wrap modulo memory size.
  assign widx = i_alu_result[NB_WADDR+1:2];
  assign lane = i_alu_result[1:0];

  always_comb begin
    misaligned = 1'b0;
    if (i_mem_read || i_mem_write) begin
      if (i_width == 2'b01)  misaligned = lane[0];
      else if (i_width[1])   misaligned = (lane != 2'b00);
    end
  end

  assign both  = i_mem_read & i_mem_write;
  assign we    = i_mem_write & ~i_stall & ~misaligned;
  assign ld_ok = i_mem_read & ~i_mem_write & ~misaligned;

  // Narrow store data is replicated across lanes; the byte enables pick the lane.
  always_comb begin
    be    = '1;
    wdata = i_write_data;
    case (i_width)
      2'b00: begin
        be    = NB_LANE'(1) << lane;
        wdata = {NB_LANE{i_write_data[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? NB_LANE'(4'b1100) : NB_LANE'(4'b0011);
        wdata = {(NB_LANE/2){i_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane_we = be & {NB_LANE{we}};

  mem_lane #(.NB_WADDR(NB_WADDR)) u_lane [NB_LANE-1:0] (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_we    (lane_we),
    .i_waddr (widx),
    .i_wdata (wdata),
    .o_rdata (rword)
  );

  assign ld_byte = rword[lane*8 +: 8];
  assign ld_half = rword[lane[1]*16 +: 16];

  always_comb begin
    case (i_width)
      2'b00:   ld_data = {{(NB_REG-8){i_sign_ext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{(NB_REG-16){i_sign_ext & ld_half[15]}}, ld_half};
      default: ld_data = rword;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_rd_addr    <= '0;
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (!i_stall) begin
      o_read_data  <= ld_ok ? ld_data : '0;
      o_alu_result <= i_alu_result;
      o_rd_addr    <= i_rd_addr;
      o_reg_write  <= i_reg_write & ~misaligned & ~both;
      o_mem_to_reg <= i_mem_to_reg;
      o_misaligned <= misaligned;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-addressed reference memory predicts each
// registered response; a monitor compares one response per clock edge.

module tb_mem_stage;
  localparam int NB_REG = 32, NB_WADDR = 6, NBYTES = 4*(2**NB_WADDR);

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NB_REG-1:0] alu = '0, wd = '0;
  logic              mrd = 1'b0, mwr = 1'b0, sx = 1'b0, rw = 1'b0, m2r = 1'b0, stall = 1'b0;
  logic [1:0]        width = 2'b11;
  logic [4:0]        rda = '0;
  logic [NB_REG-1:0] o_rdata, o_alu;
  logic [4:0]        o_rda;
  logic              o_rw, o_m2r, o_mis;

  mem_stage #(.NB_REG(NB_REG), .NB_WADDR(NB_WADDR)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_alu_result(alu), .i_write_data(wd),
    .i_mem_read(mrd), .i_mem_write(mwr), .i_width(width), .i_sign_ext(sx),
    .i_reg_write(rw), .i_mem_to_reg(m2r), .i_rd_addr(rda), .i_stall(stall),
    .o_read_data(o_rdata), .o_alu_result(o_alu), .o_rd_addr(o_rda),
    .o_reg_write(o_rw), .o_mem_to_reg(o_m2r), .o_misaligned(o_mis)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rda;
    logic        rw, m2r, mis;
  } exp_t;

  exp_t       q[$];
  exp_t       last = '0;
  logic [7:0] mm [NBYTES];
  int         n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
  endtask

  // Reference: a request is misaligned when the address is not a multiple of its size.
  task automatic issue(input bit r, input bit w, input bit [1:0] wid, input bit s,
                       input bit [31:0] a, input bit [31:0] d, input bit regw,
                       input bit mtr, input bit [4:0] rd, input bit st);
    exp_t e;
    int sz, base;
    bit [31:0] v;
    @(negedge clk);
    alu = a; wd = d; mrd = r; mwr = w; width = wid; sx = s;
    rw = regw; m2r = mtr; rda = rd; stall = st;
    if (st) begin
      q.push_back(last);
      return;
    end
    sz   = (wid == 2'b00) ? 1 : (wid == 2'b01) ? 2 : 4;
    base = int'(a % NBYTES);
    e.alu = a; e.rda = rd; e.m2r = mtr; e.rdata = '0;
    e.mis = (r || w) && (a % sz != 0);
    e.rw  = regw && !e.mis && !(r && w);
    if (r && !w && !e.mis) begin
      v = '0;
      for (int k = 0; k < sz; k++) v = v + (32'(mm[base+k]) << (8*k));
      if (s && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      e.rdata = v;
    end
    if (w && !e.mis)
      for (int k = 0; k < sz; k++) mm[base+k] = 8'(d >> (8*k));
    last = e;
    q.push_back(e);
  endtask

  task automatic idle(input bit [31:0] a, input bit [4:0] rd);
    issue(0, 0, 2'b11, 0, a, 32'h0, 1, 0, rd, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdata"}, o_rdata, '0);
    chk({tag, "_alu"},   o_alu,   '0);
    chk({tag, "_rda"},   32'(o_rda), '0);
    chk({tag, "_rw"},    32'(o_rw),  '0);
    chk({tag, "_m2r"},   32'(o_m2r), '0);
    chk({tag, "_mis"},   32'(o_mis), '0);
  endtask

  // Monitor: every edge registers one response; compare it once it has settled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("read_data",  o_rdata,     e.rdata);
        chk("alu_result", o_alu,       e.alu);
        chk("rd_addr",    32'(o_rda),  32'(e.rda));
        chk("reg_write",  32'(o_rw),   32'(e.rw));
        chk("mem_to_reg", 32'(o_m2r),  32'(e.m2r));
        chk("misaligned", 32'(o_mis),  32'(e.mis));
      end
    end
  end

  initial begin
    int op;
    bit [31:0] a;
    for (int i = 0; i < NBYTES; i++) mm[i] = '0;
    #3 chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Directed sequence
    issue(0, 1, 2'b11, 0, 32'h8, 32'hDEADBEEF, 0, 0, 0, 0);   // SW
    issue(1, 0, 2'b11, 0, 32'h8, 32'h0, 1, 1, 5'd3, 0);        // LW
    issue(1, 0, 2'b00, 1, 32'h9, 32'h0, 1, 1, 5'd4, 0);        // LB
    issue(1, 0, 2'b00, 0, 32'h9, 32'h0, 1, 1, 5'd4, 0);        // LBU
    issue(1, 0, 2'b01, 1, 32'hA, 32'h0, 1, 1, 5'd5, 0);        // LH
    issue(1, 0, 2'b01, 0, 32'hA, 32'h0, 1, 1, 5'd5, 0);        // LHU
    issue(0, 1, 2'b00, 0, 32'hB, 32'h11, 0, 0, 0, 0);          // SB
    issue(1, 0, 2'b11, 0, 32'h8, 32'h0, 1, 1, 5'd6, 0);
    issue(0, 1, 2'b01, 0, 32'h8, 32'h2222, 0, 0, 0, 0);        // SH
    issue(1, 0, 2'b11, 0, 32'h8, 32'h0, 1, 1, 5'd6, 0);
    issue(1, 0, 2'b11, 0, 32'h6, 32'h0, 1, 1, 5'd8, 0);        // misaligned LW
    issue(0, 1, 2'b01, 0, 32'h9, 32'h3333, 0, 0, 0, 0);        // misaligned SH
    issue(1, 0, 2'b11, 0, 32'h8, 32'h0, 1, 1, 5'd6, 0);
    issue(0, 1, 2'b11, 0, 32'h4, 32'h5, 0, 0, 0, 1);           // stalled SW
    issue(1, 0, 2'b11, 0, 32'h4, 32'h0, 1, 1, 5'd9, 0);
    idle(32'h3, 5'd7);
    issue(1, 1, 2'b11, 0, 32'h10, 32'hCAFEF00D, 1, 1, 5'd2, 0); // read+write
    issue(1, 0, 2'b10, 0, 32'h10, 32'h0, 1, 1, 5'd2, 0);        // width 10 = word
    issue(0, 1, 2'b11, 0, 32'h10C, 32'h12345678, 0, 0, 0, 0);   // wraps to 0xC
    issue(1, 0, 2'b11, 0, 32'hC, 32'h0, 1, 0, 5'd1, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 3) << 8) | $urandom_range(0, 31);
      issue(op inside {[4:8]}, op inside {[0:3], 8}, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom_range(0, 9) == 0);
    end

    // Reset between edges during a store
    issue(0, 1, 2'b11, 0, 32'h8, 32'hA5A5A5A5, 0, 0, 0, 0);
    @(negedge clk);
    alu = 32'h8; wd = 32'hFFFFFFFF; mwr = 1'b1; mrd = 1'b0; width = 2'b11; stall = 1'b0;
    rw = 1'b1; m2r = 1'b1; rda = 5'd9;
    #1;
    rst_n = 1'b0;
    #1 chk_zero("async_reset");
    for (int i = 0; i < NBYTES; i++) mm[i] = '0;
    last = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mwr = 1'b0;
    issue(1, 0, 2'b11, 0, 32'h8, 32'h0, 1, 1, 5'd10, 0);
    idle(32'h0, 5'd0);
    idle(32'h0, 5'd0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d want=0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
